booth_pp_accumulator: RTL and testbench

- Downstream of the PPG radix-4 Booth partial-product generator; consumes one set per beat (pp0..pp3, neg0..neg3) from PPG for an 8x8 signed multiply.
- Folds each set into a signed product and accumulates a group of products into one dot-product result. A group is, for example, the 9 taps of a 3x3 convolution window.
- Two-stage pipeline with valid/ready handshakes on both sides. Output feeds the NPU's activation/output buffer.

---
 rtl/booth_pp_accumulator.sv | 136 +++++++++++++
 tb/tb_booth_pp_accumulator.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_pp_accumulator.sv
// booth_pp_accumulator
// Takes one radix-4 Booth partial-product set per beat and folds it into a
// signed 8x8 product. Accumulates a group of those products into one
// dot-product result. Two registered stages: fold (A) and accumulate (B).
// Both sides use valid/ready handshakes. A held, unaccepted result freezes
// the whole pipeline.
module booth_pp_accumulator #(
    parameter int ACC_W     = 19,
    parameter int MAX_TERMS = 15,
    parameter int CNT_W     = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_last,
    input  logic [11:0]      pp0,
    input  logic [9:0]       pp1,
    input  logic [9:0]       pp2,
    input  logic [9:0]       pp3,
    input  logic             neg0,
    input  logic             neg1,
    input  logic             neg2,
    input  logic             neg3,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic [CNT_W-1:0] out_terms,
    output logic             out_ovf
);

    // Booth sign-extension compensation, added once per product.
    // This is -45056, which is 19'h75000 sign-extended to ACC_W.
    localparam logic [ACC_W-1:0] COMP    = ACC_W'(-45056);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_TERMS);

    logic             stall;
    logic             accept;
    logic [ACC_W-1:0] prod_fold;

    logic             valid_a;
    logic             last_a;
    logic [ACC_W-1:0] prod_a;

    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             ovf;
    logic             first;

    logic [ACC_W-1:0] acc_next;
    logic [CNT_W-1:0] cnt_next;
    logic             ovf_next;

    // A result that is waiting for its consumer freezes every stage.
    always_comb begin
        stall    = out_valid & ~out_ready;
        in_ready = ~stall;
        accept   = in_valid & in_ready;
    end

    // Weight the partial products and negate bits by their Booth positions,
    // then add the sign-extension compensation. All arithmetic wraps mod 2^ACC_W.
    always_comb begin
        prod_fold = ACC_W'(pp0)
                  + (ACC_W'(pp1) << 2)
                  + (ACC_W'(pp2) << 4)
                  + (ACC_W'(pp3) << 6)
                  + ACC_W'(neg0)
                  + (ACC_W'(neg1) << 2)
                  + (ACC_W'(neg2) << 4)
                  + (ACC_W'(neg3) << 6)
                  + COMP;
    end

    // Stage A: capture the folded product on accept.
    // An unused cycle leaves a bubble in the stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_a <= 1'b0;
            last_a  <= 1'b0;
            prod_a  <= '0;
        end else if (!stall) begin
            valid_a <= accept;
            if (accept) begin
                last_a <= in_last;
                prod_a <= prod_fold;
            end
        end
    end

    // The next accumulator, count and overflow values.
    // The first beat of a group restarts all three.
    // The count saturates at MAX_TERMS.
    // Overflow is flagged once a beat arrives while the count is already saturated.
    always_comb begin
        acc_next = (first ? '0 : acc) + prod_a;
        if (first) begin
            cnt_next = CNT_W'(1);
            ovf_next = 1'b0;
        end else begin
            cnt_next = (cnt == MAX_CNT) ? MAX_CNT : cnt + CNT_W'(1);
            ovf_next = ovf | (cnt == MAX_CNT);
        end
    end

    // Stage B and the output registers.
    // The accumulator is updated with each stage-A product.
    // A last beat loads the result and re-arms the group.
    // When no new result loads, the current one is released.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            first     <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_terms <= '0;
            out_ovf   <= 1'b0;
        end else if (!stall) begin
            out_valid <= valid_a & last_a;
            if (valid_a) begin
                acc   <= acc_next;
                cnt   <= cnt_next;
                ovf   <= ovf_next;
                first <= last_a;
                if (last_a) begin
                    out_data  <= acc_next;
                    out_terms <= cnt_next;
                    out_ovf   <= ovf_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_booth_pp_accumulator.sv
// tb_booth_pp_accumulator
// Drives signed operand pairs through a radix-4 Booth encoder into the
// accumulator. Expected group results come from plain integer multiplication
// and summation kept in a queue. Directed cases pin known literal results.
module tb_booth_pp_accumulator;

    localparam int ACC_W     = 19;
    localparam int MAX_TERMS = 15;
    localparam int CNT_W     = 4;

    logic             clk       = 1'b0;
    logic             reset     = 1'b1;
    logic             in_valid  = 1'b0;
    logic             in_ready;
    logic             in_last   = 1'b0;
    logic [11:0]      pp0       = '0;
    logic [9:0]       pp1       = '0;
    logic [9:0]       pp2       = '0;
    logic [9:0]       pp3       = '0;
    logic             neg0      = 1'b0;
    logic             neg1      = 1'b0;
    logic             neg2      = 1'b0;
    logic             neg3      = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [ACC_W-1:0] out_data;
    logic [CNT_W-1:0] out_terms;
    logic             out_ovf;

    typedef struct packed {
        logic [ACC_W-1:0] data;
        logic [CNT_W-1:0] terms;
        logic             ovf;
    } result_t;

    result_t          exp_q[$];
    result_t          mon_exp;
    result_t          mon_new;
    longint           g_sum = 0;
    int               g_cnt = 0;
    logic signed [7:0] cur_a = '0;
    logic signed [7:0] cur_b = '0;
    bit               ready_random = 1'b0;
    bit               ready_force  = 1'b1;
    bit               prev_hold    = 1'b0;
    logic [ACC_W-1:0] prev_data;
    logic [CNT_W-1:0] prev_terms;
    logic             prev_ovf;
    int               total = 0;
    int               bad   = 0;
    logic signed [7:0] corner_vals [6];
    int               grp_len;
    bit               found;

    booth_pp_accumulator #(
        .ACC_W    (ACC_W),
        .MAX_TERMS(MAX_TERMS),
        .CNT_W    (CNT_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_last  (in_last),
        .pp0      (pp0),
        .pp1      (pp1),
        .pp2      (pp2),
        .pp3      (pp3),
        .neg0     (neg0),
        .neg1     (neg1),
        .neg2     (neg2),
        .neg3     (neg3),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_terms(out_terms),
        .out_ovf  (out_ovf)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // The consumer's ready: either random or forced to a fixed level.
    always @(posedge clk) begin
        #2;
        out_ready = ready_random ? ($urandom_range(0, 9) < 7) : ready_force;
    end

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    function automatic logic signed [7:0] rand_op();
        case ($urandom_range(0, 7))
            0:       return 8'h80;
            1:       return 8'h7F;
            2:       return 8'hFF;
            3:       return 8'h00;
            4:       return 8'h01;
            default: return 8'($urandom());
        endcase
    endfunction

    task automatic apply_idle();
        in_valid = 1'b0;
        in_last  = 1'($urandom());
        pp0      = 12'($urandom());
        pp1      = 10'($urandom());
        pp2      = 10'($urandom());
        pp3      = 10'($urandom());
        {neg0, neg1, neg2, neg3} = 4'($urandom());
    endtask

    // Booth-encodes a times b, presents the set and waits until it is accepted.
    task automatic applyStimulus(input logic signed [7:0] a, input logic signed [7:0] b, input logic last);
        logic [8:0]        ybits;
        logic [8:0]        p;
        logic signed [9:0] m;
        int                d;
        bit                ok;
        ybits = {b, 1'b0};
        for (int i = 0; i < 4; i++) begin
            d = -2 * int'(ybits[2*i+2]) + int'(ybits[2*i+1]) + int'(ybits[2*i]);
            m = 10'(((d < 0) ? -d : d) * int'(a));
            p = (d < 0) ? ~m[8:0] : m[8:0];
            case (i)
                0: begin pp0 = {~p[8], p[8], p[8], p}; neg0 = (d < 0); end
                1: begin pp1 = {~p[8], p};             neg1 = (d < 0); end
                2: begin pp2 = {~p[8], p};             neg2 = (d < 0); end
                default: begin pp3 = {~p[8], p};       neg3 = (d < 0); end
            endcase
        end
        cur_a    = a;
        cur_b    = b;
        in_last  = last;
        in_valid = 1'b1;
        ok = 1'b0;
        for (int t = 0; t < 300 && !ok; t++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
        end
        if (!ok) begin
            total++;
            bad++;
            $display("[TB] FAIL accept_timeout got=in_ready low exp=accepted");
        end
    endtask

    task automatic wait_result(input string name);
        bit seen;
        seen = 1'b0;
        for (int t = 0; t < 300 && !seen; t++) begin
            @(negedge clk);
            seen = out_valid;
        end
        if (!seen) begin
            total++;
            bad++;
            $display("[TB] FAIL %s got=no out_valid exp=out_valid", name);
        end
    endtask

    task automatic settle(input int n);
        apply_idle();
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Compare process: mirrors the handshake at the upcoming edge.
    // Every released result is checked against the scoreboard.
    // Held results must stay stable.
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            g_sum     = 0;
            g_cnt     = 0;
            prev_hold = 1'b0;
        end else begin
            checkOutput("in_ready", in_ready, !(out_valid && !out_ready));
            if (prev_hold) begin
                checkOutput("hold_valid", out_valid, 1);
                checkOutput("hold_data", out_data, prev_data);
                checkOutput("hold_terms", out_terms, prev_terms);
                checkOutput("hold_ovf", out_ovf, prev_ovf);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL spurious_result got=%0h exp=none", out_data);
                end else begin
                    mon_exp = exp_q.pop_front();
                    checkOutput("sb_data", out_data, mon_exp.data);
                    checkOutput("sb_terms", out_terms, mon_exp.terms);
                    checkOutput("sb_ovf", out_ovf, mon_exp.ovf);
                end
            end
            if (in_valid && in_ready) begin
                g_sum += longint'(cur_a) * longint'(cur_b);
                g_cnt++;
                if (in_last) begin
                    mon_new.data  = ACC_W'(g_sum);
                    mon_new.terms = (g_cnt > MAX_TERMS) ? CNT_W'(MAX_TERMS) : CNT_W'(g_cnt);
                    mon_new.ovf   = (g_cnt > MAX_TERMS);
                    exp_q.push_back(mon_new);
                    g_sum = 0;
                    g_cnt = 0;
                end
            end
            prev_hold  = out_valid && !out_ready;
            prev_data  = out_data;
            prev_terms = out_terms;
            prev_ovf   = out_ovf;
        end
    end

    // Watchdog so the run can never hang.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed cases first, then randomized groups, then a final drain.
    initial begin
        corner_vals = '{8'h80, 8'h81, 8'hFF, 8'h00, 8'h01, 8'h7F};
        apply_idle();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("rst_valid", out_valid, 0);
        checkOutput("rst_data", out_data, 0);
        checkOutput("rst_terms", out_terms, 0);
        checkOutput("rst_ovf", out_ovf, 0);
        checkOutput("rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;

        $display("[TB] single term 5 x 3");
        applyStimulus(8'sd5, 8'sd3, 1'b1);
        apply_idle();
        @(negedge clk);
        checkOutput("lat_early", out_valid, 0);
        @(negedge clk);
        checkOutput("lat_valid", out_valid, 1);
        checkOutput("single_data", out_data, 15);
        checkOutput("single_terms", out_terms, 1);
        checkOutput("single_ovf", out_ovf, 0);
        settle(2);

        $display("[TB] nine terms of -128 x -128");
        for (int i = 0; i < 9; i++) applyStimulus(8'sh80, 8'sh80, i == 8);
        apply_idle();
        wait_result("nine_pos_wait");
        checkOutput("nine_pos_data", out_data, 32'h24000);
        checkOutput("nine_pos_terms", out_terms, 9);
        checkOutput("nine_pos_ovf", out_ovf, 0);
        settle(2);

        $display("[TB] nine terms of -128 x 127");
        for (int i = 0; i < 9; i++) applyStimulus(8'sh80, 8'sd127, i == 8);
        apply_idle();
        wait_result("nine_neg_wait");
        checkOutput("nine_neg_data", out_data, 32'h5C480);
        checkOutput("nine_neg_terms", out_terms, 9);
        settle(2);

        $display("[TB] single-term sweep");
        for (int i = 0; i < 6; i++)
            for (int j = 0; j < 6; j++)
                applyStimulus(corner_vals[i], corner_vals[j], 1'b1);
        for (int i = 0; i < 1000; i++) applyStimulus(8'($urandom()), 8'($urandom()), 1'b1);
        settle(4);

        $display("[TB] backpressure");
        ready_random = 1'b0;
        ready_force  = 1'b0;
        fork
            begin
                applyStimulus(8'sd10, 8'sd10, 1'b1);
                applyStimulus(8'sd3, 8'sd4, 1'b0);
                applyStimulus(-8'sd5, 8'sd6, 1'b0);
                applyStimulus(8'sd7, 8'sd7, 1'b1);
                apply_idle();
            end
            begin
                wait_result("bp_first_wait");
                repeat (5) begin
                    @(negedge clk);
                    checkOutput("bp_in_ready", in_ready, 0);
                    checkOutput("bp_first_data", out_data, 100);
                end
                ready_force = 1'b1;
            end
        join
        found = 1'b0;
        for (int t = 0; t < 50 && !found; t++) begin
            @(negedge clk);
            found = out_valid && (out_terms == 4'd3);
        end
        checkOutput("bp_second_seen", found, 1);
        checkOutput("bp_second_data", out_data, 31);
        settle(2);

        $display("[TB] overflow");
        for (int i = 0; i < 16; i++) applyStimulus(8'sd1, 8'sd1, i == 15);
        apply_idle();
        wait_result("ovf_wait");
        checkOutput("ovf_terms", out_terms, 15);
        checkOutput("ovf_flag", out_ovf, 1);
        checkOutput("ovf_data", out_data, 16);
        @(posedge clk);
        #1;
        applyStimulus(8'sd2, 8'sd2, 1'b1);
        apply_idle();
        wait_result("post_ovf_wait");
        checkOutput("post_ovf_flag", out_ovf, 0);
        checkOutput("post_ovf_data", out_data, 4);
        checkOutput("post_ovf_terms", out_terms, 1);
        settle(2);

        $display("[TB] reset mid-group");
        for (int i = 0; i < 4; i++) applyStimulus(rand_op(), rand_op(), 1'b0);
        apply_idle();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("mid_rst_valid", out_valid, 0);
        checkOutput("mid_rst_data", out_data, 0);
        checkOutput("mid_rst_terms", out_terms, 0);
        checkOutput("mid_rst_ovf", out_ovf, 0);
        checkOutput("mid_rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        applyStimulus(8'sd7, -8'sd6, 1'b1);
        apply_idle();
        wait_result("post_rst_wait");
        checkOutput("post_rst_data", out_data, 32'h7FFD6);
        checkOutput("post_rst_terms", out_terms, 1);
        checkOutput("post_rst_ovf", out_ovf, 0);
        settle(2);

        $display("[TB] randomized groups");
        ready_random = 1'b1;
        for (int g = 0; g < 250; g++) begin
            grp_len = $urandom_range(1, 20);
            for (int k = 0; k < grp_len; k++) begin
                if ($urandom_range(0, 4) == 0) begin
                    apply_idle();
                    @(posedge clk);
                    #1;
                end
                applyStimulus(rand_op(), rand_op(), k == grp_len - 1);
            end
        end
        apply_idle();

        ready_random = 1'b0;
        ready_force  = 1'b1;
        for (int t = 0; t < 200 && exp_q.size() != 0; t++) @(negedge clk);
        checkOutput("drain_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
